// File: rtl/seq_cd_array_mul_if.sv
// Operand/result streaming bus for seq_cd_array_mul: valid/ready operand channel in,
// valid/ready product channel out.
interface seq_cd_array_mul_if #(
  parameter int AW = 8,
  parameter int BW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     a;
  logic [BW-1:0]     b;
  logic              approx_en;
  logic              out_valid;
  logic              out_ready;
  logic [AW+BW-1:0]  r;
  logic              r_approx;

  modport master (
    output in_valid, a, b, approx_en, out_ready,
    input  in_ready, out_valid, r, r_approx
  );

  modport slave (
    input  in_valid, a, b, approx_en, out_ready,
    output in_ready, out_valid, r, r_approx
  );
endinterface

// File: rtl/seq_cd_array_mul.sv
// Sequential AWxBW unsigned multiplier, one partial-product row per clock, with an optional
// carry-disregard mode that XORs (rather than adds) the low DROP_COLS result columns.
module seq_cd_array_mul #(
  parameter int AW        = 8,
  parameter int BW        = 4,
  parameter int DROP_COLS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_cd_array_mul_if.slave bus
);
  localparam int RW = AW + BW;
  localparam int CW = $clog2(BW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [RW-1:0]   a_sh_reg;
  logic [BW-1:0]   b_sh_reg;
  logic            approx_reg;
  logic [CW-1:0]   cnt_reg;
  logic [RW-1:0]   acc_reg, acc_next;
  logic [RW-1:0]   r_reg;
  logic            r_approx_reg;

  logic [RW-1:0]   lo_mask;
  logic [RW-1:0]   hi_keep, lo_keep, row;
  logic            last_row;

  generate
    for (genvar gi = 0; gi < RW; gi++) begin : g_lo_mask
      assign lo_mask[gi] = (gi < DROP_COLS);
    end
  endgenerate

  // The accumulator holds HI|LO: HI columns are summed exactly (their low bits stay zero),
  // LO columns collect the XOR of their partial products with no carry out.
  assign hi_keep  = approx_reg ? ~lo_mask : {RW{1'b1}};
  assign lo_keep  = approx_reg ? lo_mask  : {RW{1'b0}};
  assign row      = b_sh_reg[0] ? a_sh_reg : {RW{1'b0}};
  assign acc_next = ((acc_reg & hi_keep) + (row & hi_keep)) | ((acc_reg ^ row) & lo_keep);

  // RUN spans BW+1 cycles: BW row additions plus one cycle to publish the result.
  assign last_row = (cnt_reg == CW'(BW));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (last_row)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      approx_reg   <= 1'b0;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      r_reg        <= '0;
      r_approx_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_reg   <= RW'(bus.a);
            b_sh_reg   <= bus.b;
            approx_reg <= bus.approx_en;
            cnt_reg    <= '0;
            acc_reg    <= '0;
          end
        end
        RUN: begin
          acc_reg  <= acc_next;
          a_sh_reg <= a_sh_reg << 1;
          b_sh_reg <= b_sh_reg >> 1;
          cnt_reg  <= cnt_reg + CW'(1);
          if (last_row) begin
            r_reg        <= acc_reg;
            r_approx_reg <= approx_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.r         = r_reg;
  assign bus.r_approx  = r_approx_reg;
endmodule
